uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_core.sv | 75 +++++++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the arbitrated UART transmitter.
package uart_pkg;

    localparam int DEFAULT_DELAY_FRAMES = 234;
    localparam int TX_CNT_MIN_W         = 13;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWN
    } arb_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: latches a byte on start while idle, then sends start, 8 data bits LSB first, stop.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       uart_tx
);
    localparam int CNT_W = ($clog2(DELAY_FRAMES) > TX_CNT_MIN_W) ? $clog2(DELAY_FRAMES) : TX_CNT_MIN_W;

    tx_state_e        r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [2:0]       r_bit, w_bit_next;
    logic [7:0]       r_data, w_data_next;
    logic             w_bit_done;

    assign w_bit_done = (r_cnt == CNT_W'(DELAY_FRAMES - 1));
    assign ready      = (r_state == TX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_data  <= w_data_next;
        end
    end

    // NOTE: every next-state value gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_bit_done ? '0 : r_cnt + CNT_W'(1);
        w_bit_next   = r_bit;
        w_data_next  = r_data;
        case (r_state)
            TX_IDLE: begin
                w_cnt_next = '0;
                w_bit_next = '0;
                if (start) begin
                    w_data_next  = data;
                    w_state_next = TX_START;
                end
            end
            TX_START: if (w_bit_done) w_state_next = TX_DATA;
            TX_DATA: begin
                if (w_bit_done) begin
                    w_bit_next = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_next = TX_STOP;
                end
            end
            TX_STOP: if (w_bit_done) w_state_next = TX_IDLE;
            default: w_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        case (r_state)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = r_data[r_bit];
            default:  uart_tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter with idle-lock timeout feeding a single UART serializer.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 16 * DELAY_FRAMES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 uart_tx
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);

    arb_state_e        r_arb_state, w_arb_next;
    logic [NUM_REQ-1:0] r_grant, w_grant_next;
    logic [IDX_W-1:0]  r_owner, w_owner_next;
    logic [IDX_W-1:0]  r_last_owner, w_last_owner_next;
    logic [LOCK_W-1:0] r_lock_cnt, w_lock_next;
    logic              w_tx_ready, w_owner_valid, w_owner_last, w_accept, w_pick_found;
    logic [IDX_W-1:0]  w_pick_idx, w_cand;
    logic [IDX_W:0]    w_sum;
    logic [7:0]        w_tx_data;

    assign w_owner_valid = |(req_valid & r_grant);
    assign w_owner_last  = |(req_last & r_grant);
    assign req_ready     = r_grant & {NUM_REQ{w_tx_ready}};
    assign w_accept      = |(req_valid & req_ready);
    assign grant         = r_grant;
    assign busy          = !w_tx_ready;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_sum        = '0;
        w_cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last_owner} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(NUM_REQ)) w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
            w_cand = w_sum[IDX_W-1:0];
            if (!w_pick_found && req_valid[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_tx_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) w_tx_data = req_data[i*8 +: 8];
        end
    end

    always_comb begin
        w_arb_next        = r_arb_state;
        w_grant_next      = r_grant;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_lock_next       = '0;
        case (r_arb_state)
            ARB_IDLE: begin
                if (w_pick_found) begin
                    w_arb_next   = ARB_OWN;
                    w_grant_next = NUM_REQ'(1) << w_pick_idx;
                    w_owner_next = w_pick_idx;
                end
            end
            ARB_OWN: begin
                if (w_accept) begin
                    if (w_owner_last) begin
                        w_arb_next        = ARB_IDLE;
                        w_grant_next      = '0;
                        w_last_owner_next = r_owner;
                    end
                end else if (w_tx_ready && !w_owner_valid) begin
                    if (r_lock_cnt == LOCK_W'(LOCK_TIMEOUT - 1)) begin
                        w_arb_next        = ARB_IDLE;
                        w_grant_next      = '0;
                        w_last_owner_next = r_owner;
                    end else begin
                        w_lock_next = r_lock_cnt + LOCK_W'(1);
                    end
                end else begin
                    w_lock_next = r_lock_cnt;
                end
            end
            default: w_arb_next = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses nonblocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arb_state  <= ARB_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_lock_cnt   <= '0;
        end else begin
            r_arb_state  <= w_arb_next;
            r_grant      <= w_grant_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_owner_next;
            r_lock_cnt   <= w_lock_next;
        end
    end

    uart_tx_core #(
        .DELAY_FRAMES(DELAY_FRAMES)
    ) u_tx_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_accept),
        .data   (w_tx_data),
        .ready  (w_tx_ready),
        .uart_tx(uart_tx)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: expected owners and bytes are queued with the stimulus and checked on accept / on the line.
module tb_uart_tx_arbiter;
    localparam int DF = 4;
    localparam int NR = 4;
    localparam int LT = 64;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] grant;
    logic          busy;
    logic          uart_tx;

    uart_tx_arbiter #(
        .DELAY_FRAMES(DF),
        .NUM_REQ     (NR),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .grant    (grant),
        .busy     (busy),
        .uart_tx  (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [8:0] src_q[NR][$];
    int         exp_owner[$];
    logic [7:0] exp_bytes[$];
    int         acc_times[$];
    logic [NR-1:0] acc_mask = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic offer(input int r, input logic [7:0] b, input logic last);
        src_q[r].push_back({last, b});
    endtask

    task automatic expect_acc(input int r, input logic [7:0] b);
        exp_owner.push_back(r);
        exp_bytes.push_back(b);
    endtask

    function automatic int pending();
        int s;
        s = exp_owner.size() + exp_bytes.size();
        for (int i = 0; i < NR; i++) s += src_q[i].size();
        return s;
    endfunction

    task automatic wait_drain(input int budget);
        int n;
        int pend;
        n    = 0;
        pend = pending();
        while ((pend != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
            pend = pending();
        end
        check("drain_pending", pend + int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_uart_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_ready", req_ready, 0);
        for (int i = 0; i < NR; i++) src_q[i].delete();
        exp_owner.delete();
        exp_bytes.delete();
        acc_times.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_first_accept(output int t_acc);
        int n;
        n = 0;
        while (acc_times.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_seen", acc_times.size() > 0, 1);
        t_acc = (acc_times.size() > 0) ? acc_times[0] : 0;
    endtask

    // Requester model: present queue heads, retire a byte the edge after it was accepted.
    initial begin : drv
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = src_q[i][0][7:0];
                    req_last[i]        = src_q[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    initial begin : acc_mon
        int own;
        forever begin
            @(negedge clk);
            acc_mask = (rst_n === 1'b1) ? (req_valid & req_ready) : '0;
            if (acc_mask != '0) begin
                check("acc_onehot", $countones(acc_mask), 1);
                check("acc_tx_idle", busy, 0);
                check("acc_expected", exp_owner.size() > 0, 1);
                own = (exp_owner.size() > 0) ? exp_owner.pop_front() : 0;
                check("acc_grant", grant, 32'(1) << own);
                acc_times.push_back(cyc);
            end
        end
    end

    // Line receiver: checks framing cycle by cycle and samples each bit mid-way.
    initial begin : rx_mon
        logic [7:0] exp_b;
        logic [7:0] rx_b;
        int         err;
        bit         aborted;
        logic       cur;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                check("rx_expected", exp_bytes.size() > 0, 1);
                exp_b = 8'h00;
                if (exp_bytes.size() > 0) exp_b = exp_bytes.pop_front();
                check("rx_busy", busy, 1);
                rx_b    = '0;
                err     = 0;
                aborted = 1'b0;
                cur     = 1'b0;
                for (int c = 1; c < 10 * DF; c++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c < DF) begin
                        if (uart_tx !== 1'b0) err++;
                    end else if (c < 9 * DF) begin
                        if ((c - DF) % DF == 0) cur = uart_tx;
                        else if (uart_tx !== cur) err++;
                        if ((c - DF) % DF == DF / 2) rx_b = {uart_tx, rx_b[7:1]};
                    end else if (uart_tx !== 1'b1) begin
                        err++;
                    end
                end
                if (!aborted) begin
                    check("rx_byte", rx_b, exp_b);
                    check("rx_frame", err, 0);
                end
            end
        end
    end

    initial begin : main
        int t_acc;
        int n;
        int bad;
        rst_n = 1'b0;
        @(negedge clk);

        // Single byte, minimum latency.
        do_reset();
        offer(0, 8'h55, 1'b1);
        expect_acc(0, 8'h55);
        @(negedge clk);
        check("lat_grant_c0", grant, 4'b0000);
        @(negedge clk);
        check("lat_grant_c1", grant, 4'b0001);
        check("lat_ready_c1", req_ready, 4'b0001);
        @(negedge clk);
        check("lat_start_c2", uart_tx, 0);
        check("lat_grant_c2", grant, 4'b0000);
        wait_drain(200);

        // Two simultaneous single-byte requesters.
        do_reset();
        offer(1, 8'h31, 1'b1);
        offer(2, 8'h32, 1'b1);
        expect_acc(1, 8'h31);
        expect_acc(2, 8'h32);
        wait_drain(300);

        // Multi-byte packet is not preempted.
        do_reset();
        offer(0, 8'hA1, 1'b0);
        offer(0, 8'hA2, 1'b0);
        offer(0, 8'hA3, 1'b1);
        offer(3, 8'h3D, 1'b1);
        expect_acc(0, 8'hA1);
        expect_acc(0, 8'hA2);
        expect_acc(0, 8'hA3);
        expect_acc(3, 8'h3D);
        bad = 0;
        n   = 0;
        while (src_q[0].size() > 0 && n < 400) begin
            @(negedge clk);
            if (grant[3] === 1'b1) bad++;
            n++;
        end
        check("no_preempt", bad, 0);
        wait_drain(300);

        // Idle owner loses grant after the lock timeout.
        do_reset();
        offer(0, 8'h10, 1'b0);
        offer(2, 8'h20, 1'b1);
        expect_acc(0, 8'h10);
        expect_acc(2, 8'h20);
        wait_first_accept(t_acc);
        n = 0;
        while (grant[0] === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("lock_drop_gap", cyc - t_acc, 10 * DF + 1 + LT);
        @(negedge clk);
        check("grant_after_lock", grant, 4'b0100);
        wait_drain(300);

        // All requesters busy: round-robin order and back-to-back spacing.
        do_reset();
        for (int i = 0; i < NR; i++) offer(i, 8'(i), 1'b1);
        offer(0, 8'h04, 1'b1);
        for (int i = 0; i < NR; i++) expect_acc(i, 8'(i));
        expect_acc(0, 8'h04);
        wait_drain(600);
        check("rr_accept_count", acc_times.size(), 5);
        for (int k = 1; k < acc_times.size(); k++)
            check("accept_spacing", acc_times[k] - acc_times[k-1], 10 * DF + 1);

        // Reset in the middle of data bit 3, then a clean frame.
        do_reset();
        offer(1, 8'h52, 1'b1);
        expect_acc(1, 8'h52);
        wait_first_accept(t_acc);
        n = 0;
        while (cyc < t_acc + 5 * DF - 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bit3_low_before_rst", uart_tx, 0);
        do_reset();
        offer(2, 8'hC3, 1'b1);
        expect_acc(2, 8'hC3);
        wait_drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
